// File: rtl/jtcop_rom_slot32.sv
// One-entry 32-bit ROM slot cache in front of a 16-bit SDRAM port.
// A miss fetches two consecutive SDRAM words into a single 32-bit entry.
module jtcop_rom_slot32 #(
  parameter int          AW     = 18,
  parameter logic [21:0] OFFSET = 22'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] slot_addr,
  input  logic          slot_cs,
  input  logic          slot_clr,
  output logic          slot_ok,
  output logic [31:0]   slot_dout,
  output logic [21:0]   sdram_addr,
  output logic          sdram_req,
  input  logic          sdram_ack,
  input  logic          data_dst,
  input  logic          data_rdy,
  input  logic [15:0]   data_read
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] cached_addr;
  logic [AW-1:0] req_addr;
  logic [31:0]   cached_data;
  logic          valid;
  logic          cnt;
  logic          full;
  logic          killed;
  logic          hit;
  logic          start;
  logic [AW:0]   word_addr;

  assign hit       = valid && (slot_addr == cached_addr);
  assign start     = (state == IDLE) && slot_cs && !hit;
  assign slot_ok   = slot_cs && hit && (state == IDLE);
  assign slot_dout = cached_data;
  assign sdram_req = (state == REQ);
  // req_addr only moves on REQ entry, so the address is stable per fetch
  assign word_addr  = {req_addr, 1'b0};
  assign sdram_addr = OFFSET + 22'(word_addr);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = REQ;
      REQ:  if (sdram_ack) state_nx = WAIT;
      WAIT: if (data_rdy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cached_addr <= '0;
      req_addr    <= '0;
      cached_data <= '0;
      valid       <= 1'b0;
      cnt         <= 1'b0;
      full        <= 1'b0;
      killed      <= 1'b0;
    end else begin
      state <= state_nx;
      if (start) begin
        req_addr <= slot_addr;
        cnt      <= 1'b0;
        full     <= 1'b0;
        killed   <= 1'b0;
        valid    <= 1'b0;
      end
      if (state == WAIT) begin
        if (data_dst && !full) begin
          if (!cnt) cached_data[15:0]  <= data_read;
          else      cached_data[31:16] <= data_read;
          cnt  <= ~cnt;
          full <= cnt;
        end
        if (data_rdy) begin
          valid       <= !killed;
          cached_addr <= req_addr;
        end
      end
      // a clear during a fetch lets it finish but keeps the entry invalid
      if (slot_clr) begin
        valid <= 1'b0;
        if (state != IDLE) killed <= 1'b1;
      end
    end
  end

endmodule
